// File: rtl/tile_port_arbiter.sv
// tile_port_arbiter: packet-level round-robin arbiter for one tile output
// direction. A grant is held until the granted source's last beat, and then
// priority rotates. A 1-deep register stage drives the neighbour link.
module tile_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic [15:0]                     beat_count
);

  localparam int unsigned GW       = $clog2(NUM_REQ);
  localparam int unsigned CW       = 16;
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state;
  logic [GW-1:0]           rr_ptr;
  logic                    can_load;
  logic                    accept;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic                    hi_found;
  logic [GW-1:0]           hi_idx;
  logic                    grant_valid;
  logic                    grant_last;
  logic [DATA_WIDTH-1:0]   grant_data;

  // Output register can take a new beat when it is empty or draining this cycle.
  assign can_load = !out_valid || out_ready;

  // Round-robin search: first valid index at or above rr_ptr, else wrap to the lowest valid.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    hi_found   = 1'b0;
    hi_idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = GW'(i);
      end
      if (req_valid[i] && (GW'(i) >= rr_ptr) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = GW'(i);
      end
    end
    if (hi_found) begin
      pick_idx = hi_idx;
    end
  end

  // Select the granted source and decode its ready; every other source sees ready low.
  always_comb begin
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    grant_data  = '0;
    req_ready   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == grant_id) begin
        grant_valid  = req_valid[i];
        grant_last   = req_last[i];
        grant_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = (state == LOCKED) && can_load;
      end
    end
  end

  assign accept = (state == LOCKED) && grant_valid && can_load;

  // Arbitration FSM: grant in IDLE, hold the lock until the last beat is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            state    <= LOCKED;
            grant_id <= pick_idx;
            busy     <= 1'b1;
          end
        end
        LOCKED: begin
          if (accept && grant_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on accept, otherwise empty once the neighbour takes the beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_last  <= grant_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of neighbour handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_count <= '0;
    end else if (out_valid && out_ready && (beat_count != CNT_MAX)) begin
      beat_count <= beat_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_tile_port_arbiter.sv
// Bench for tile_port_arbiter: per-source beat queues drive the requesters,
// a scoreboard queue holds the expected output beat order, and a monitor
// pops it on every neighbour handshake.
module tb_tile_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;
  localparam int unsigned GW = 2;

  typedef logic [DW:0] beat_t;   // {last, data}

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic [NR-1:0]       req_valid;
  logic [NR*DW-1:0]    req_data;
  logic [NR-1:0]       req_last;
  logic [NR-1:0]       req_ready;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic                out_ready;
  logic [GW-1:0]       grant_id;
  logic                busy;
  logic [15:0]         beat_count;

  beat_t src_q [NR][$];
  beat_t sb_q [$];
  int    n_chk  = 0;
  int    n_fail = 0;

  always #5 clock = ~clock;

  tile_port_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_count (beat_count)
  );

  function automatic beat_t mk(input int r, input int p, input int b, input bit last);
    return {last, 8'(r), 8'(p), 16'(b)};
  endfunction

  function automatic logic [DW-1:0] mk_data(input int r, input int p, input int b);
    beat_t t;
    t = mk(r, p, b, 1'b0);
    return t[DW-1:0];
  endfunction

  function automatic bit src_pending();
    bit any = 1'b0;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present the head beat of each source queue.
  task automatic drive_srcs();
    beat_t h;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() != 0) begin
        h = src_q[i][0];
        req_valid[i]           = 1'b1;
        req_last[i]            = h[DW];
        req_data[i*DW +: DW]   = h[DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // Queue a packet on source r and record its beats in expected output order.
  task automatic push_pkt(input int r, input int p, input int nb);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b = mk(r, p, k, k == nb - 1);
      src_q[r].push_back(b);
      sb_q.push_back(b);
    end
    drive_srcs();
  endtask

  // One clock: note source handshakes before the edge, advance the queues after it.
  task automatic tick();
    logic [NR-1:0] hs;
    @(negedge clock);
    hs = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++)
      if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive_srcs();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || src_pending()) && n < budget) begin
      tick();
      n++;
    end
    n_chk++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d beats left, expected 0", name, sb_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    sb_q.delete();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive_srcs();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every neighbour handshake must match the next expected beat.
  always @(negedge clock) begin
    beat_t e;
    if (!reset && out_valid && out_ready) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat: got unexpected %0h expected none", {out_last, out_data});
      end else begin
        e = sb_q.pop_front();
        if ({out_last, out_data} !== e) begin
          n_fail++;
          $display("FAIL beat: got %0h expected %0h", {out_last, out_data}, e);
        end
      end
    end
  end

  initial begin
    logic [12:0] ov_pat;
    logic [1:0]  gnt_exp [4];
    int          gi;
    beat_t       b;

    reset     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tick();
    do_reset();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_beat_count", 32'(beat_count), 0);

    // 1: single 4-beat packet on source 0
    push_pkt(0, 1, 4);
    tick();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_grant", 32'(grant_id), 0);
    chk("t1_out_valid_c1", 32'(out_valid), 0);
    chk("t1_req_ready", 32'(req_ready), 32'b001);
    tick();
    chk("t1_out_valid_c2", 32'(out_valid), 1);
    chk("t1_first_data", out_data, mk_data(0, 1, 0));
    tick();
    tick();
    tick();
    chk("t1_last_valid", 32'(out_valid), 1);
    chk("t1_last", 32'(out_last), 1);
    tick();
    chk("t1_drained", 32'(out_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_beat_count", 32'(beat_count), 4);

    // 2: all sources, 2-beat packets, expected grant order 0,1,2,0
    do_reset();
    push_pkt(0, 2, 2);
    push_pkt(1, 3, 2);
    push_pkt(2, 4, 2);
    push_pkt(0, 5, 2);
    ov_pat = 13'b0110110110110;
    gnt_exp[0] = 2'd0; gnt_exp[1] = 2'd1; gnt_exp[2] = 2'd2; gnt_exp[3] = 2'd0;
    gi = 0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("t2_out_valid_c%0d", k), 32'(out_valid), 32'(ov_pat[k-1]));
      if (k % 3 == 1 && gi < 4) begin
        chk($sformatf("t2_grant_%0d", gi), 32'(grant_id), 32'(gnt_exp[gi]));
        gi++;
      end
    end
    chk("t2_beat_count", 32'(beat_count), 8);
    chk("t2_sb_empty", 32'(sb_q.size()), 0);

    // 3: neighbour stall mid-packet (rr_ptr now 1)
    push_pkt(1, 6, 4);
    tick();
    chk("t3_grant", 32'(grant_id), 1);
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_stall_valid", 32'(out_valid), 1);
      chk("t3_stall_data", out_data, mk_data(1, 6, 1));
      chk("t3_stall_ready", 32'(req_ready), 0);
    end
    out_ready = 1'b1;
    wait_drain("t3_drain", 50);
    chk("t3_beat_count", 32'(beat_count), 12);

    // 4: enable low blocks new grants but not a locked packet (rr_ptr now 2)
    enable = 1'b0;
    push_pkt(1, 7, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_no_grant_busy", 32'(busy), 0);
      chk("t4_no_grant_valid", 32'(out_valid), 0);
    end
    enable = 1'b1;
    tick();
    chk("t4_grant_busy", 32'(busy), 1);
    chk("t4_grant", 32'(grant_id), 1);
    enable = 1'b0;
    wait_drain("t4_drain1", 50);
    tick();
    chk("t4_done_busy", 32'(busy), 0);
    push_pkt(0, 8, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_held_busy", 32'(busy), 0);
      chk("t4_grant_hold", 32'(grant_id), 1);
    end
    enable = 1'b1;
    tick();
    chk("t4_single_grant", 32'(grant_id), 0);
    wait_drain("t4_drain2", 50);

    // 5: reset during beat 2 of 4 (rr_ptr now 1, so source 2 wins)
    tick();
    push_pkt(2, 9, 4);
    tick();
    chk("t5_grant", 32'(grant_id), 2);
    tick();
    tick();
    do_reset();
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_last", 32'(out_last), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_grant", 32'(grant_id), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_count", 32'(beat_count), 0);
    push_pkt(0, 10, 1);
    push_pkt(2, 11, 1);
    tick();
    chk("t5_ptr_restart", 32'(grant_id), 0);
    wait_drain("t5_drain", 50);
    chk("t5_beat_count", 32'(beat_count), 2);

    // 6: beat counter saturation
    do_reset();
    for (int k = 0; k < 65540; k++) begin
      b = mk(0, 12, k, k == 65539);
      src_q[0].push_back(b);
      sb_q.push_back(b);
    end
    drive_srcs();
    wait_drain("t6_drain", 70000);
    tick();
    chk("t6_saturate", 32'(beat_count), 32'hFFFF);
    chk("t6_sb_empty", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
